cache_ctrl: RTL

Miss/write sequencer for the 32-set, 4-word-line, direct-mapped data cache of the RV32F core. It compares the valid bit and tag returned by the cache for the current CPU address and stalls the pipeline on misses and stores. It fetches whole 128-bit lines from data memory on read misses and writes stores through to memory. It drives the cache write-enable and write-mode (word/line) controls and keeps saturating hit/miss statistics.

---
 rtl/cache_ctrl.sv | 65 ++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: miss/write-through sequencer for a direct-mapped 32x4-word data cache with saturating hit/miss counters.
module cache_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_re,
  input  logic             cpu_we,
  input  logic [9:0]       cpu_addr,
  input  logic             cache_v,
  input  logic [2:0]       cache_tag,
  input  logic             mem_ready,
  output logic             stall,
  output logic             cache_we,
  output logic             w_h,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [7:0]       mem_line_addr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam logic [1:0] IDLE = 2'd0, RD_MEM = 2'd1, FILL = 2'd2, WR_MEM = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic             refill_q, refill_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic             hit, rd, idle, wr;
  assign hit  = cache_v & (cache_tag == cpu_addr[9:7]);
  assign rd   = cpu_re & ~cpu_we;
  assign idle = state_q == IDLE;
  assign wr   = state_q == WR_MEM;
  always_comb begin
    state_d  = idle ? (cpu_we ? WR_MEM : (rd & ~hit) ? RD_MEM : IDLE) :
               state_q == RD_MEM ? (mem_ready ? FILL : RD_MEM) :
               state_q == FILL ? IDLE : (mem_ready ? IDLE : WR_MEM);
    addr_d   = (idle && state_d != IDLE) ? cpu_addr[9:2] : addr_q;
    refill_d = state_q == FILL;
    // The access replayed right after a fill hits, but it was already counted as a miss.
    hit_d    = (idle & rd & hit & ~refill_q & ~&hit_q) ? hit_q + CNT_W'(1) : hit_q;
    miss_d   = (idle & rd & ~hit & ~&miss_q) ? miss_q + CNT_W'(1) : miss_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      refill_q <= refill_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end
  assign stall         = idle ? (cpu_we | (rd & ~hit)) : wr ? ~mem_ready : 1'b1;
  assign cache_we      = (state_q == FILL) | (wr & mem_ready & hit);
  assign w_h           = state_q != FILL;
  assign mem_req       = (state_q == RD_MEM) | wr;
  assign mem_wr        = wr;
  assign mem_line_addr = addr_q;
  assign hit_cnt       = hit_q;
  assign miss_cnt      = miss_q;
endmodule
